// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for the counter arbiter slice.
//   state_t        : arbiter FSM states (IDLE, COUNT, DONE)
//   CNT_W_DEFAULT  : default width of the shared interval counter
package counter_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CNT_W_DEFAULT = 4;

endpackage

// File: rtl/interval_counter.sv
// Loadable down-counter shared by all requesters of the arbiter.
// Ports:
//   clock_i    : clock, rising edge
//   reset_i    : asynchronous active-low reset, clears the count to 0
//   load_i     : load load_val_i (has priority over dec_i)
//   load_val_i : value to load
//   dec_i      : decrement by one; the count saturates at 0
//   data_o     : current count
module interval_counter
  import counter_arbiter_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic [W-1:0] data_o
);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      data_o <= '0;
    end else if (load_i) begin
      data_o <= load_val_i;
    end else if (dec_i && (data_o != '0)) begin
      data_o <= data_o - 1'b1;
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that grants one requester at a time an interval of
// len+1 cycles timed by a shared down-counter, followed by a one-cycle
// completion pulse.
// Ports:
//   clock_i : clock, rising edge
//   reset_i : asynchronous active-low reset
//   req_i   : per-requester level request
//   len_i   : per-requester interval length, slice k = [k*CNT_W +: CNT_W]
//   gnt_o   : one-hot grant, high while the owner's interval runs
//   done_o  : one-hot, one-cycle completion pulse to the owner
//   busy_o  : high whenever the FSM is not in IDLE
//   cnt_o   : current value of the shared counter
//   state_o : FSM state, for debug and checkers
//
// Handshake: a requester raises req_i[k] and holds it; gnt_o[k] rises when
// it wins. Holding req_i[k] until done_o[k] pulses completes the interval;
// dropping req_i[k] while granted aborts it with no done_o pulse. Requests
// and lengths of non-owners are ignored until the FSM returns to IDLE.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] len_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         cnt_o,
  output state_t                   state_o
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q;
  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   owner_q;

  logic [PTR_W-1:0]   win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [CNT_W-1:0]   win_len;
  logic               any_req;
  logic               owner_req;
  logic               cnt_zero;
  logic               cnt_load;
  logic               cnt_dec;

  // Round-robin search starting at ptr+1. Walking the offsets from the
  // farthest back to the nearest lets the nearest requesting index win.
  always_comb begin : rr_select
    int cand;
    cand    = 0;
    win_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (req_i[cand[PTR_W-1:0]]) win_idx = cand[PTR_W-1:0];
    end
  end

  always_comb begin : win_decode
    win_onehot = '0;
    win_len    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == PTR_W'(k)) begin
        win_onehot[k] = 1'b1;
        win_len       = len_i[k*CNT_W +: CNT_W];
      end
    end
  end

  assign any_req   = |req_i;
  assign owner_req = req_i[owner_q];
  assign cnt_zero  = (cnt_o == '0);
  assign cnt_load  = (state_q == IDLE) && any_req;
  assign cnt_dec   = (state_q == COUNT) && owner_req && !cnt_zero;

  interval_counter #(
    .W (CNT_W)
  ) u_interval_counter (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .load_i     (cnt_load),
    .load_val_i (win_len),
    .dec_i      (cnt_dec),
    .data_o     (cnt_o)
  );

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      gnt_o   <= '0;
      done_o  <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      owner_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q <= COUNT;
            gnt_o   <= win_onehot;
            owner_q <= win_idx;
          end
        end
        COUNT: begin
          if (!owner_req) begin
            // Abort: release without a completion pulse.
            state_q <= IDLE;
            gnt_o   <= '0;
            ptr_q   <= owner_q;
          end else if (cnt_zero) begin
            state_q <= DONE;
            done_o  <= gnt_o;
            gnt_o   <= '0;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_o  <= '0;
          ptr_q   <= owner_q;
        end
        default: begin
          state_q <= IDLE;
          gnt_o   <= '0;
          done_o  <= '0;
        end
      endcase
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign state_o = state_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Self-checking bench for counter_arbiter (NUM_REQ=2, CNT_W=4).
// Directed scenarios followed by randomized traffic, all compared every
// cycle against a cycle-offset reference model of the arbitration rules.
module tb_counter_arbiter;

  localparam int N  = 2;
  localparam int CW = 4;

  // ---------------- clock / reset ----------------
  logic clock_i = 1'b0;
  logic reset_i;
  always #5 clock_i = ~clock_i;

  logic [N-1:0]    req_i;
  logic [N*CW-1:0] len_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    done_o;
  logic            busy_o;
  logic [CW-1:0]   cnt_o;
  counter_arbiter_pkg::state_t state_o;

  counter_arbiter #(
    .NUM_REQ (N),
    .CNT_W   (CW)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .req_i   (req_i),
    .len_i   (len_i),
    .gnt_o   (gnt_o),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .cnt_o   (cnt_o),
    .state_o (state_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An interval is described by its owner, its length and the edge index
  // at which it was granted; everything else follows from the offset of the
  // current edge from that grant edge.
  localparam int P_FREE = 0;
  localparam int P_HELD = 1;
  localparam int P_DONE = 2;

  int m_phase, m_ptr, m_owner, m_len, m_g, m_cyc, m_cnt;

  task automatic model_reset();
    m_phase = P_FREE;
    m_ptr   = N - 1;
    m_owner = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N*CW-1:0] l);
    int j;
    int c;
    m_cyc++;
    if (m_phase == P_HELD) begin
      j = m_cyc - m_g;
      if (!r[m_owner]) begin
        m_phase = P_FREE;
        m_ptr   = m_owner;
        m_cnt   = (m_len - (j - 1) > 0) ? m_len - (j - 1) : 0;
      end else if (j > m_len) begin
        m_phase = P_DONE;
        m_cnt   = 0;
      end else begin
        m_cnt = m_len - j;
      end
    end else if (m_phase == P_DONE) begin
      m_phase = P_FREE;
      m_ptr   = m_owner;
    end else if (r != '0) begin
      for (int i = 1; i <= N; i++) begin
        c = (m_ptr + i) % N;
        if (r[c]) begin
          m_owner = c;
          break;
        end
      end
      m_len   = int'((l >> (m_owner * CW)) & 8'h0F);
      m_g     = m_cyc;
      m_cnt   = m_len;
      m_phase = P_HELD;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    logic [N-1:0] ed;
    eg = '0;
    ed = '0;
    if (m_phase == P_HELD) eg[m_owner] = 1'b1;
    if (m_phase == P_DONE) ed[m_owner] = 1'b1;
    check_eq({tag, ".gnt"},  32'(gnt_o),  32'(eg));
    check_eq({tag, ".done"}, 32'(done_o), 32'(ed));
    check_eq({tag, ".busy"}, 32'(busy_o), (m_phase != P_FREE) ? 32'd1 : 32'd0);
    check_eq({tag, ".cnt"},  32'(cnt_o),  32'(m_cnt));
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input string tag);
    @(posedge clock_i);
    if (reset_i) model_step(req_i, len_i);
    else model_reset();
    #1;
    check_outputs(tag);
  endtask

  // Called 1 time unit after an edge; releases well before the next edge.
  task automatic reset_pulse(input string tag);
    #1 reset_i = 1'b0;
    model_reset();
    #1 check_outputs(tag);
    #2 reset_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int gcyc, dcyc, rises, idle_between, dseen;
    logic found;
    logic [N-1:0] prev_gnt;
    logic [31:0] seen[$];

    m_cyc = 0;
    model_reset();

    // Reset held for 99 time units with both requesters asserted.
    reset_i = 1'b0;
    req_i   = 2'b11;
    len_i   = {4'd5, 4'd3};
    #20 check_outputs("rst_a");
    #30 check_outputs("rst_b");
    #30 check_outputs("rst_c");
    #19 reset_i = 1'b1;

    // First grant goes to requester 0; len 3 gives 4 grant cycles,
    // counter 3,2,1,0 then 0 during the done cycle.
    gcyc = 0;
    dcyc = 0;
    for (int k = 0; k < 6; k++) begin
      step("s1");
      if (k == 0) req_i = 2'b01;
      if (gnt_o == 2'b01) gcyc++;
      if (done_o == 2'b01) dcyc++;
      if (k < 5) seen.push_back(32'(cnt_o));
    end
    check_eq("s1_gnt_cycles", gcyc, 4);
    check_eq("s1_done_cycles", dcyc, 1);
    exp_q = '{32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
    while (exp_q.size() > 0 && seen.size() > 0) check_eq("s1_cnt_seq", seen.pop_front(), exp_q.pop_front());
    req_i = 2'b00;
    step("s1_idle");

    // Abort: requester 0 drops at cnt=5 of len 9, requester 1 follows.
    len_i = {4'd2, 4'd9};
    req_i = 2'b01;
    step("s33");
    req_i = 2'b11;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (cnt_o == 4'd5 && gnt_o == 2'b01) begin
        found = 1'b1;
        break;
      end
      step("s33_run");
    end
    check_eq("s33_reach", 32'(found), 32'd1);
    req_i = 2'b10;
    step("s33_abort");
    check_eq("s33_abort_gnt", 32'(gnt_o), 32'd0);
    check_eq("s33_abort_done", 32'(done_o), 32'd0);
    step("s33_next");
    check_eq("s33_next_gnt", 32'(gnt_o), 32'b10);
    for (int k = 0; k < 4; k++) step("s33_fin");
    req_i = 2'b00;
    step("s33_idle");

    // Both held: grants alternate 0,1,0,1 with one idle cycle in between.
    len_i = {4'd1, 4'd2};
    req_i = 2'b11;
    exp_q = '{32'd0, 32'd1, 32'd0, 32'd1};
    prev_gnt = 2'b00;
    rises = 0;
    idle_between = 0;
    for (int k = 0; k < 18; k++) begin
      step("s31");
      if (gnt_o != 2'b00 && prev_gnt == 2'b00) begin
        rises++;
        if (exp_q.size() > 0) check_eq("s31_order", (gnt_o == 2'b10) ? 32'd1 : 32'd0, exp_q.pop_front());
      end
      if (rises >= 1 && rises < 4 && !busy_o) idle_between++;
      prev_gnt = gnt_o;
    end
    check_eq("s31_rises", rises, 4);
    check_eq("s31_idle_gaps", idle_between, 3);
    req_i = 2'b00;
    step("s31_idle");

    // Zero length: done follows the single grant cycle.
    len_i = {4'd0, 4'd0};
    req_i = 2'b01;
    step("s32");
    check_eq("s32_gnt", 32'(gnt_o), 32'b01);
    step("s32_d");
    check_eq("s32_done", 32'(done_o), 32'b01);
    req_i = 2'b00;
    step("s32_i");
    step("s32_i2");

    // Reset mid-interval: outputs clear at once and no done follows.
    len_i = {4'd0, 4'd6};
    req_i = 2'b01;
    for (int k = 0; k < 3; k++) step("s34");
    req_i = 2'b00;
    reset_pulse("s34_rst");
    dseen = 0;
    for (int k = 0; k < 10; k++) begin
      step("s34_post");
      if (done_o != 2'b00) dseen++;
    end
    check_eq("s34_no_done", dseen, 0);

    // Randomized traffic with occasional reset pulses.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) len_i = {4'($urandom_range(0, 5)), 4'($urandom_range(0, 5))};
      step("rnd");
      if (c % 97 == 50) reset_pulse("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
